// File: rtl/sha_computational_block.sv
// Single-block SHA-256 engine: pads a message of up to 55 bytes into one 512-bit block and
// runs the 64 compression rounds one per clock, then presents the digest with a level flag.
module sha_computational_block (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [439:0] inputMsg,
   input  logic         beginComputation,
   output logic         computationComplete,
   output logic [255:0] SHAoutput
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t      state;
   logic [5:0]  t;
   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] w [0:15];

   logic [5:0]   msg_len;
   logic [511:0] padded;
   logic [31:0]  t1, t2, w_next;

   // Length is set by the last non-zero byte, so trailing zero bytes fall outside the message.
   always_comb begin
      msg_len = '0;
      for (int i = 0; i < 55; i++) begin
         if (inputMsg[439-8*i -: 8] != 8'h00) msg_len = 6'(i + 1);
      end
      padded = {inputMsg, 72'd0};
      for (int i = 0; i < 56; i++) begin
         if (msg_len == 6'(i)) padded[511-8*i -: 8] = 8'h80;
      end
      padded[63:0] = {55'd0, msg_len, 3'b000};
   end

   // w[0] always holds W[t]; w_next is W[t+16], shifted in as the window advances.
   always_comb begin
      t1     = h + big_sig1(e) + ((e & f) ^ (~e & g)) + K[t] + w[0];
      t2     = big_sig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      w_next = small_sig1(w[14]) + w[9] + small_sig0(w[1]) + w[0];
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state               <= IDLE;
         computationComplete <= 1'b0;
         SHAoutput           <= '0;
         t                   <= '0;
         {a, b, c, d, e, f, g, h} <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (beginComputation) begin
                  for (int i = 0; i < 16; i++) w[i] <= padded[511-32*i -: 32];
                  {a, b, c, d, e, f, g, h} <= IV;
                  t                   <= '0;
                  computationComplete <= 1'b0;
                  state               <= ROUND;
               end
            end
            ROUND: begin
               h <= g;
               g <= f;
               f <= e;
               e <= d + t1;
               d <= c;
               c <= b;
               b <= a;
               a <= t1 + t2;
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_next;
               t     <= t + 6'd1;
               if (t == 6'd63) state <= FINAL;
            end
            FINAL: begin
               SHAoutput <= {IV[255:224] + a, IV[223:192] + b, IV[191:160] + c, IV[159:128] + d,
                             IV[127:96]  + e, IV[95:64]   + f, IV[63:32]   + g, IV[31:0]    + h};
               computationComplete <= 1'b1;
               state               <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha_computational_block.sv
// Bench for sha_computational_block: directed FIPS vectors plus random messages scored
// against an array-based SHA-256 model; a monitor pops expected digests on each completion.
module tb_sha_computational_block;

   logic         clk;
   logic         n_rst;
   logic [439:0] inputMsg;
   logic         beginComputation;
   logic         computationComplete;
   logic [255:0] SHAoutput;

   int n_compared   = 0;
   int n_mismatched = 0;
   logic [255:0] expected_q [$];

   localparam logic [255:0] DIGEST_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIGEST_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [439:0] MSG_ABC      = {24'h616263, 416'd0};

   localparam logic [31:0] IV_TB [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K_TB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   sha_computational_block dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .inputMsg            (inputMsg),
      .beginComputation    (beginComputation),
      .computationComplete (computationComplete),
      .SHAoutput           (SHAoutput)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference: byte-level padding from the known length, full 64-entry schedule, array-rotated state.
   function automatic logic [255:0] refDigest(input logic [439:0] msg, input int len);
      logic [7:0]  blk [0:63];
      logic [31:0] w [0:63];
      logic [31:0] r [0:7];
      logic [31:0] s0, s1, t1, t2;
      logic [63:0] bit_len;
      for (int i = 0; i < 64; i++) blk[i] = 8'h00;
      for (int i = 0; i < len; i++) blk[i] = msg[439-8*i -: 8];
      blk[len] = 8'h80;
      bit_len = 64'(len) * 64'd8;
      for (int i = 0; i < 8; i++) blk[56+i] = bit_len[63-8*i -: 8];
      for (int i = 0; i < 16; i++) w[i] = {blk[4*i], blk[4*i+1], blk[4*i+2], blk[4*i+3]};
      for (int i = 16; i < 64; i++) begin
         s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      for (int i = 0; i < 8; i++) r[i] = IV_TB[i];
      for (int i = 0; i < 64; i++) begin
         t1 = r[7] + (rr(r[4], 6) ^ rr(r[4], 11) ^ rr(r[4], 25)) + ((r[4] & r[5]) ^ (~r[4] & r[6])) + K_TB[i] + w[i];
         t2 = (rr(r[0], 2) ^ rr(r[0], 13) ^ rr(r[0], 22)) + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
         for (int j = 7; j > 0; j--) r[j] = r[j-1];
         r[4] = r[4] + t1;
         r[0] = t1 + t2;
      end
      return {IV_TB[0] + r[0], IV_TB[1] + r[1], IV_TB[2] + r[2], IV_TB[3] + r[3],
              IV_TB[4] + r[4], IV_TB[5] + r[5], IV_TB[6] + r[6], IV_TB[7] + r[7]};
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Starts one computation, holding begin for 'hold' edges and optionally pulsing begin with a
   // scrambled message at edge 'pulse_at' mid-run; checks complete drops and rises on edge 65.
   task automatic applyStimulus(input logic [439:0] msg, input logic [255:0] exp,
                                input int hold, input int pulse_at);
      int k;
      @(negedge clk);
      inputMsg         = msg;
      beginComputation = 1'b1;
      expected_q.push_back(exp);
      @(posedge clk);
      #1;
      checkOutput("complete_drop", 256'(computationComplete), 256'd0);
      for (k = 1; k <= 230; k++) begin
         beginComputation = (k < hold) || (k == pulse_at);
         if (k == pulse_at) inputMsg = {$urandom, $urandom, $urandom, $urandom, 312'd0};
         @(posedge clk);
         #1;
         if (computationComplete) break;
      end
      beginComputation = 1'b0;
      checkOutput("latency", 256'(k), 256'd65);
   endtask

   // Monitor: every rising edge of complete consumes one expected digest.
   initial begin
      logic prev_complete;
      logic [255:0] exp;
      prev_complete = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_rst && computationComplete && !prev_complete) begin
            if (expected_q.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_complete: got digest %h, expected none", SHAoutput);
            end else begin
               exp = expected_q.pop_front();
               checkOutput("digest", SHAoutput, exp);
            end
         end
         prev_complete = computationComplete;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [439:0] msg;
      int len;
      int byte_val;

      n_rst            = 1'b1;
      inputMsg         = '0;
      beginComputation = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_complete", 256'(computationComplete), 256'd0);
      checkOutput("reset_digest", SHAoutput, 256'd0);
      @(negedge clk);
      n_rst = 1'b0;

      $display("[TB] empty message");
      applyStimulus(440'd0, DIGEST_EMPTY, 1, 0);

      $display("[TB] abc from DONE with mid-run begin pulse and message change");
      applyStimulus(MSG_ABC, DIGEST_ABC, 1, 20);

      $display("[TB] begin held for several cycles");
      applyStimulus(MSG_ABC, DIGEST_ABC, 4, 0);

      $display("[TB] reset during round 30");
      @(negedge clk);
      inputMsg         = 440'd0;
      beginComputation = 1'b1;
      @(posedge clk);
      #1;
      beginComputation = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      n_rst = 1'b1;
      #1;
      checkOutput("abort_complete", 256'(computationComplete), 256'd0);
      checkOutput("abort_digest", SHAoutput, 256'd0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b0;
      applyStimulus(440'd0, DIGEST_EMPTY, 1, 0);

      $display("[TB] back-to-back restart from DONE");
      applyStimulus(MSG_ABC, DIGEST_ABC, 1, 0);

      $display("[TB] random messages");
      for (int n = 0; n < 10; n++) begin
         if (n == 0) len = 55;
         else if (n == 1) len = 1;
         else len = $urandom_range(0, 55);
         msg = '0;
         for (int i = 0; i < len; i++) begin
            byte_val = $urandom_range(0, 255);
            if (i == len - 1 && byte_val == 0) byte_val = 8'h5a;
            msg[439-8*i -: 8] = 8'(byte_val);
         end
         applyStimulus(msg, refDigest(msg, len), 1, 0);
      end

      repeat (4) @(negedge clk);
      checkOutput("queue_drained", 256'(expected_q.size()), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
